// File: rtl/pix_reg_pkg.sv
// pix_reg_pkg: register offsets, reset values and the sensor parameter bundle for pix_reg_bank
package pix_reg_pkg;
  localparam logic [2:0] OFS_STREAM_EN = 3'd0;
  localparam logic [2:0] OFS_SOFT_TRIG = 3'd1;
  localparam logic [2:0] OFS_EXP       = 3'd2;
  localparam logic [2:0] OFS_GAIN      = 3'd3;
  localparam logic [2:0] OFS_ROI_W     = 3'd4;
  localparam logic [2:0] OFS_ROI_H     = 3'd5;
  localparam logic [2:0] OFS_FRAME_CNT = 3'd6;
  localparam logic [2:0] OFS_VERSION   = 3'd7;
  localparam logic [15:0] RST_EXP     = 16'h0100;
  localparam logic [15:0] RST_GAIN    = 16'h0000;
  localparam logic [15:0] RST_ROI_W   = 16'h0A20;
  localparam logic [15:0] RST_ROI_H   = 16'h0798;
  localparam logic [15:0] VERSION_VAL = 16'h5A01;
  typedef struct packed {
    logic [15:0] exp;
    logic [15:0] gain;
    logic [15:0] roi_w;
    logic [15:0] roi_h;
  } pix_param_t;
  localparam pix_param_t PARAM_RST = '{exp: RST_EXP, gain: RST_GAIN, roi_w: RST_ROI_W, roi_h: RST_ROI_H};
endpackage

// File: rtl/pix_reg_bank_if.sv
// pix_reg_bank_if: SPI-slave-side register access bus (strobes, address, data, select, readback)
interface pix_reg_bank_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          pix_sel;
  modport master (output wr_en, rd_en, addr, wr_data, input pix_sel, rd_data);
  modport slave  (input wr_en, rd_en, addr, wr_data, output pix_sel, rd_data);
endinterface

// File: rtl/pulse_sync_edge.sv
// pulse_sync_edge: 3-FF synchroniser of the SPI write strobe with an armed flag and a rising-edge commit
module pulse_sync_edge (
  input  logic clk_pix,
  input  logic reset_pix,
  input  logic i_pulse,
  output logic o_commit
);
  logic [2:0] sync_q, sync_d;
  logic [1:0] live_q, live_d;
  logic       armed_q, armed_d;
  // sync2 only holds a real strobe sample two cycles after reset; arm on the first such low sample
  always_comb begin
    sync_d  = {sync_q[1:0], i_pulse};
    live_d  = {live_q[0], 1'b1};
    armed_d = armed_q | (live_q[1] & ~sync_q[1]);
  end
  assign o_commit = sync_q[1] & ~sync_q[2] & armed_q;
  // synchroniser, fill tracker and armed flag
  always_ff @(posedge clk_pix) begin
    if (reset_pix) begin
      sync_q  <= '0;
      live_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      live_q  <= live_d;
      armed_q <= armed_d;
    end
  end
endmodule

// File: rtl/pix_reg_bank.sv
// pix_reg_bank: clk_pix register bank behind the SPI slave; PIX_REG_SHADOW_EN enables frame-synchronous shadows
module pix_reg_bank
  import pix_reg_pkg::*;
#(
  parameter int                         SPI_ADDR_LENGTH = 16,
  parameter int                         SPI_DATA_LENGTH = 16,
  parameter logic [SPI_ADDR_LENGTH-1:0] REG_BASE        = 16'h0020
) (
  input  logic                  clk_pix,
  input  logic                  reset_pix,
  pix_reg_bank_if.slave         bus,
  input  logic                  i_fval,
  output logic                  o_stream_en,
  output logic                  o_soft_trigger,
  output logic [15:0]           ov_exp_line,
  output logic [15:0]           ov_gain,
  output logic [15:0]           ov_roi_width,
  output logic [15:0]           ov_roi_height
);
  logic                       commit, sel, fall, p_wr;
  logic [SPI_ADDR_LENGTH-1:0] ofs_full;
  logic [2:0]                 ofs;
  logic                       wr_vld_q, wr_vld_d;
  logic [2:0]                 wr_ofs_q, wr_ofs_d;
  logic [SPI_DATA_LENGTH-1:0] wr_dat_q, wr_dat_d;
  logic                       stream_en_q, stream_en_d;
  logic                       trig_q, trig_d;
  logic                       fval_q, fval_d;
  logic [15:0]                frame_cnt_q, frame_cnt_d;
  logic [SPI_DATA_LENGTH-1:0] rd_data_q, rd_data_d;
  pix_param_t                 param_q, param_d, p_nxt, view;
`ifdef PIX_REG_SHADOW_EN
  pix_param_t                 shadow_q, shadow_d;
  assign view = shadow_q;
`else
  assign view = param_q;
`endif

  pulse_sync_edge u_sync (
    .clk_pix  (clk_pix),
    .reset_pix(reset_pix),
    .i_pulse  (bus.wr_en),
    .o_commit (commit)
  );

  assign ofs_full       = bus.addr - REG_BASE;
  assign sel            = (bus.addr >= REG_BASE) && (ofs_full < SPI_ADDR_LENGTH'(8));
  assign ofs            = ofs_full[2:0];
  assign bus.pix_sel    = sel;
  assign bus.rd_data    = rd_data_q;
  assign o_stream_en    = stream_en_q;
  assign o_soft_trigger = trig_q;
  assign ov_exp_line    = param_q.exp;
  assign ov_gain        = param_q.gain;
  assign ov_roi_width   = param_q.roi_w;
  assign ov_roi_height  = param_q.roi_h;

  // capture the write at commit, apply it one cycle later; frame counting and readback mux
  always_comb begin
    wr_vld_d    = commit & sel & (ofs < OFS_FRAME_CNT);
    wr_ofs_d    = commit ? ofs : wr_ofs_q;
    wr_dat_d    = commit ? bus.wr_data : wr_dat_q;
    p_wr        = wr_vld_q && (wr_ofs_q >= OFS_EXP) && (wr_ofs_q <= OFS_ROI_H);
    p_nxt.exp   = (wr_vld_q && wr_ofs_q == OFS_EXP)   ? wr_dat_q : view.exp;
    p_nxt.gain  = (wr_vld_q && wr_ofs_q == OFS_GAIN)  ? wr_dat_q : view.gain;
    p_nxt.roi_w = (wr_vld_q && wr_ofs_q == OFS_ROI_W) ? wr_dat_q : view.roi_w;
    p_nxt.roi_h = (wr_vld_q && wr_ofs_q == OFS_ROI_H) ? wr_dat_q : view.roi_h;
    stream_en_d = (wr_vld_q && wr_ofs_q == OFS_STREAM_EN) ? wr_dat_q[0] : stream_en_q;
    trig_d      = wr_vld_q && wr_ofs_q == OFS_SOFT_TRIG && wr_dat_q[0];
    fval_d      = i_fval;
    fall        = fval_q & ~i_fval;
    frame_cnt_d = frame_cnt_q + {15'b0, i_fval & ~fval_q};
`ifdef PIX_REG_SHADOW_EN
    shadow_d    = p_nxt;
    param_d     = (fall | (p_wr & ~stream_en_q)) ? p_nxt : param_q;
`else
    param_d     = p_nxt;
`endif
    rd_data_d   = !sel                   ? '0 :
                  ofs == OFS_STREAM_EN   ? {15'b0, stream_en_q} :
                  ofs == OFS_EXP         ? view.exp :
                  ofs == OFS_GAIN        ? view.gain :
                  ofs == OFS_ROI_W       ? view.roi_w :
                  ofs == OFS_ROI_H       ? view.roi_h :
                  ofs == OFS_FRAME_CNT   ? frame_cnt_q :
                  ofs == OFS_VERSION     ? VERSION_VAL : '0;
  end

  // all bank state, cleared or preset on reset
  always_ff @(posedge clk_pix) begin
    if (reset_pix) begin
      wr_vld_q    <= 1'b0;
      wr_ofs_q    <= '0;
      wr_dat_q    <= '0;
      stream_en_q <= 1'b0;
      trig_q      <= 1'b0;
      fval_q      <= 1'b0;
      frame_cnt_q <= '0;
      rd_data_q   <= '0;
      param_q     <= PARAM_RST;
`ifdef PIX_REG_SHADOW_EN
      shadow_q    <= PARAM_RST;
`endif
    end else begin
      wr_vld_q    <= wr_vld_d;
      wr_ofs_q    <= wr_ofs_d;
      wr_dat_q    <= wr_dat_d;
      stream_en_q <= stream_en_d;
      trig_q      <= trig_d;
      fval_q      <= fval_d;
      frame_cnt_q <= frame_cnt_d;
      rd_data_q   <= rd_data_d;
      param_q     <= param_d;
`ifdef PIX_REG_SHADOW_EN
      shadow_q    <= shadow_d;
`endif
    end
  end
endmodule

// File: tb/tb_pix_reg_bank.sv
// tb_pix_reg_bank: randomized bench for pix_reg_bank against a register-map reference model
module tb_pix_reg_bank;
  localparam logic [15:0] BASE = 16'h0020;
`ifdef PIX_REG_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif
  logic clk_pix = 1'b0;
  logic reset_pix, i_fval;
  logic o_stream_en, o_soft_trigger;
  logic [15:0] ov_exp_line, ov_gain, ov_roi_width, ov_roi_height;
  int total = 0, bad = 0;
  logic        m_stream;
  logic [15:0] m_sh [2:5];
  logic [15:0] m_eff[2:5];
  int          m_cnt;
  logic [8:1]        trig_hist;
  logic [8:1][15:0]  gain_hist;

  pix_reg_bank_if bus ();

  pix_reg_bank dut (
    .clk_pix       (clk_pix),
    .reset_pix     (reset_pix),
    .bus           (bus),
    .i_fval        (i_fval),
    .o_stream_en   (o_stream_en),
    .o_soft_trigger(o_soft_trigger),
    .ov_exp_line   (ov_exp_line),
    .ov_gain       (ov_gain),
    .ov_roi_width  (ov_roi_width),
    .ov_roi_height (ov_roi_height)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic void m_reset();
    m_stream = 1'b0;
    m_sh[2] = 16'h0100;
    m_sh[3] = 16'h0000;
    m_sh[4] = 16'h0A20;
    m_sh[5] = 16'h0798;
    m_eff = m_sh;
    m_cnt = 0;
  endfunction

  function automatic bit in_bank(input logic [15:0] a);
    return a >= BASE && a < BASE + 16'd8;
  endfunction

  function automatic void m_write(input logic [15:0] a, input logic [15:0] d);
    int o;
    if (in_bank(a)) begin
      o = int'(a - BASE);
      if (o == 0) m_stream = d[0];
      else if (o >= 2 && o <= 5) begin
        m_sh[o] = d;
        if (!SHADOW || !m_stream) m_eff = m_sh;
      end
    end
  endfunction

  function automatic logic [15:0] m_read(input logic [15:0] a);
    int o;
    if (!in_bank(a)) return 16'h0;
    o = int'(a - BASE);
    if (o == 0) return {15'b0, m_stream};
    if (o == 1) return 16'h0;
    if (o == 6) return m_cnt[15:0];
    if (o == 7) return 16'h5A01;
    return m_sh[o];
  endfunction

  task automatic check_outs(input string tag);
    check({tag, "_stream"}, o_stream_en, m_stream);
    check({tag, "_trig"}, o_soft_trigger, 1'b0);
    check({tag, "_exp"}, ov_exp_line, m_eff[2]);
    check({tag, "_gain"}, ov_gain, m_eff[3]);
    check({tag, "_roiw"}, ov_roi_width, m_eff[4]);
    check({tag, "_roih"}, ov_roi_height, m_eff[5]);
  endtask

  task automatic wr_pulse(input logic [15:0] a, input logic [15:0] d);
    @(posedge clk_pix); #1;
    bus.addr = a;
    bus.wr_data = d;
    bus.wr_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk_pix); #1;
      if (i == 4) bus.wr_en = 1'b0;
      @(negedge clk_pix);
      trig_hist[i] = o_soft_trigger;
      gain_hist[i] = ov_gain;
    end
    m_write(a, d);
  endtask

  task automatic fval_pulse();
    @(posedge clk_pix); #1 i_fval = 1'b1;
    @(posedge clk_pix); #1 i_fval = 1'b0;
    @(posedge clk_pix); #1;
    m_cnt = (m_cnt + 1) & 32'hFFFF;
    m_eff = m_sh;
  endtask

  task automatic rd_chk(input logic [15:0] a, input string tag);
    @(posedge clk_pix); #1;
    bus.addr = a;
    bus.rd_en = 1'b1;
    @(negedge clk_pix);
    check({tag, "_sel"}, bus.pix_sel, in_bank(a));
    @(posedge clk_pix);
    @(negedge clk_pix);
    check({tag, "_data"}, bus.rd_data, m_read(a));
    bus.rd_en = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_pix = 1'b1;
    i_fval = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.addr = 16'h0;
    bus.wr_data = 16'h0;
    m_reset();
    repeat (3) @(posedge clk_pix);
    #1 reset_pix = 1'b0;
    repeat (5) @(posedge clk_pix);
    @(negedge clk_pix);
    check_outs("rst");
    check("rst_rd", bus.rd_data, 16'h0);
    rd_chk(BASE + 16'd2, "rd_exp");
    check("rd_exp_const", bus.rd_data, 16'h0100);
    rd_chk(BASE + 16'd7, "rd_ver");
    check("rd_ver_const", bus.rd_data, 16'h5A01);
    rd_chk(16'h0010, "rd_out");
    wr_pulse(BASE + 16'd3, 16'h0042);
    check("gain_c3", gain_hist[3], 16'h0000);
    check("gain_c4", gain_hist[4], 16'h0042);
    check_outs("gain");
    wr_pulse(BASE + 16'd1, 16'h0001);
    check("trig_hist1", trig_hist, 8'b0000_1000);
    rd_chk(BASE + 16'd1, "rd_trig");
    wr_pulse(BASE + 16'd1, 16'h0000);
    check("trig_hist0", trig_hist, 8'b0);
    wr_pulse(BASE + 16'd6, 16'h1234);
    rd_chk(BASE + 16'd6, "ro_cnt");
    wr_pulse(BASE + 16'd7, 16'h1234);
    rd_chk(BASE + 16'd7, "ro_ver");
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0, 1: wr_pulse(BASE - 16'd2 + 16'($urandom_range(0, 11)), 16'($urandom));
        2: fval_pulse();
        default: rd_chk(BASE - 16'd2 + 16'($urandom_range(0, 11)), "rnd_rd");
      endcase
      check_outs("rnd");
    end
    repeat (5) fval_pulse();
    rd_chk(BASE + 16'd6, "cnt5");
    @(posedge clk_pix); #1;
    force dut.frame_cnt_q = 16'hFFFE;
    #1 release dut.frame_cnt_q;
    m_cnt = 32'hFFFE;
    fval_pulse();
    rd_chk(BASE + 16'd6, "cnt_ffff");
    fval_pulse();
    rd_chk(BASE + 16'd6, "cnt_wrap");
    check("cnt_wrap_const", bus.rd_data, 16'h0000);
    wr_pulse(BASE + 16'd0, 16'h0000);
    wr_pulse(BASE + 16'd3, 16'h7777);
    @(posedge clk_pix); #1;
    bus.addr = BASE + 16'd3;
    bus.wr_data = 16'hBEEF;
    bus.wr_en = 1'b1;
    @(posedge clk_pix); #1 reset_pix = 1'b1;
    repeat (2) @(posedge clk_pix);
    #1 reset_pix = 1'b0;
    repeat (6) @(posedge clk_pix);
    #1 bus.wr_en = 1'b0;
    repeat (6) @(posedge clk_pix);
    m_reset();
    @(negedge clk_pix);
    check_outs("rst_fly");
    check("rst_fly_gain_const", ov_gain, 16'h0000);
    rd_chk(BASE + 16'd3, "rst_fly_rd");
    rd_chk(BASE + 16'd6, "rst_fly_cnt");
    wr_pulse(BASE + 16'd4, 16'h0111);
    check_outs("post_rst");
`ifdef PIX_REG_SHADOW_EN
    wr_pulse(BASE + 16'd0, 16'h0001);
    wr_pulse(BASE + 16'd2, 16'h0200);
    check("sh_hold", ov_exp_line, 16'h0100);
    check_outs("sh_hold");
    rd_chk(BASE + 16'd2, "sh_rd");
    check("sh_rd_const", bus.rd_data, 16'h0200);
    fval_pulse();
    check("sh_load", ov_exp_line, 16'h0200);
    check_outs("sh_load");
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
